// File: rtl/peak_hold_bank_if.sv
// Bundle of the peak_hold_bank control, sample and display signals.
// master drives the level samples and strobes; slave is the peak-hold bank.
interface peak_hold_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic                      enable;
  logic                      tick;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      error;
  logic                      clear_error;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CHANNELS*WIDTH-1:0] peak_out;
  logic [CHANNELS-1:0]       holding;
  logic                      error_flag;

  modport master (
    output enable, tick, load, data_in, error, clear_error,
    input  data_out, peak_out, holding, error_flag
  );

  modport slave (
    input  enable, tick, load, data_in, error, clear_error,
    output data_out, peak_out, holding, error_flag
  );
endinterface

// File: rtl/peak_hold_bank.sv
// Multi-channel level register with per-channel peak hold and timed decay.
// Each channel keeps its last sample, a peak that is held for HOLD_TICKS
// decay ticks after a new maximum, then falls by DECAY_STEP per tick but
// never below the channel's current sample. A sticky error flag records
// upstream faults; while error is high every channel is frozen.
module peak_hold_bank #(
  parameter int              WIDTH       = 8,
  parameter int              CHANNELS    = 2,
  parameter int              HOLD_TICKS  = 16,
  parameter int              DECAY_STEP  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                clock,
  input  logic                reset,
  peak_hold_bank_if.slave     bus
);

  localparam int             CW        = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_TICKS);

  logic [CHANNELS-1:0][WIDTH-1:0] sample_p0, sample_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] peak_p0, peak_nxt;
  logic [CHANNELS-1:0][CW-1:0]    cnt_p0, cnt_nxt;
  logic                           flag_p0, flag_nxt;
  logic                           upd;

  // Peak minus one decay step, clamped at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a);
    if (64'(a) >= 64'(DECAY_STEP))
      sat_sub = a - WIDTH'(DECAY_STEP);
    else
      sat_sub = '0;
  endfunction

  // Larger of two levels; used to stop decay at the live sample.
  function automatic logic [WIDTH-1:0] max_level(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    max_level = (a > b) ? a : b;
  endfunction

  assign upd = bus.enable & ~bus.error;

  // Next sample/peak/hold-counter per channel and next sticky error flag.
  always_comb begin
    sample_nxt = sample_p0;
    peak_nxt   = peak_p0;
    cnt_nxt    = cnt_p0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (upd) begin
        if (bus.load[i])
          sample_nxt[i] = bus.data_in[i*WIDTH +: WIDTH];
        // A new maximum restarts the hold and masks this cycle's tick.
        if (bus.load[i] && (bus.data_in[i*WIDTH +: WIDTH] >= peak_p0[i])) begin
          peak_nxt[i] = bus.data_in[i*WIDTH +: WIDTH];
          cnt_nxt[i]  = HOLD_LOAD;
        end else if (bus.tick) begin
          if (cnt_p0[i] != '0)
            cnt_nxt[i] = cnt_p0[i] - CW'(1);
          else
            // Floor is the post-edge sample so a same-cycle load is honoured.
            peak_nxt[i] = max_level(sat_sub(peak_p0[i]), sample_nxt[i]);
        end
      end
    end
    // Set has priority; clearing is not gated by enable.
    flag_nxt = flag_p0;
    if (bus.enable & bus.error)
      flag_nxt = 1'b1;
    else if (bus.clear_error & ~bus.error)
      flag_nxt = 1'b0;
  end

  // State register; reset loads the full-scale lamp-test pattern.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sample_p0 <= {CHANNELS{RESET_VALUE}};
      peak_p0   <= {CHANNELS{RESET_VALUE}};
      cnt_p0    <= {CHANNELS{HOLD_LOAD}};
      flag_p0   <= 1'b0;
    end else begin
      sample_p0 <= sample_nxt;
      peak_p0   <= peak_nxt;
      cnt_p0    <= cnt_nxt;
      flag_p0   <= flag_nxt;
    end
  end

  // A channel is holding while its counter has ticks left.
  always_comb begin
    bus.holding = '0;
    for (int i = 0; i < CHANNELS; i++)
      bus.holding[i] = (cnt_p0[i] != '0);
  end

  assign bus.data_out   = sample_p0;
  assign bus.peak_out   = peak_p0;
  assign bus.error_flag = flag_p0;

endmodule

// File: tb/tb_peak_hold_bank.sv
// Bench for peak_hold_bank: directed vector table, then random stimulus
// compared against a per-channel reference model.
module tb_peak_hold_bank;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int HT = 4;
  localparam int DS = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  peak_hold_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  peak_hold_bank #(
    .WIDTH(W), .CHANNELS(CH), .HOLD_TICKS(HT), .DECAY_STEP(DS),
    .RESET_VALUE(8'hFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit       rst_n;
    bit       en;
    bit       tk;
    bit [1:0] ld;
    bit [7:0] d0, d1;
    bit       err, clr;
    bit [7:0] xd0, xp0, xd1, xp1;
    bit [1:0] xh;
    bit       xf;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_s[CH];
  int m_p[CH];
  int m_h[CH];
  bit m_f;

  function automatic vec_t mk(bit r, bit en, bit tk, bit [1:0] ld,
                              bit [7:0] d0, bit [7:0] d1, bit err, bit clr,
                              bit [7:0] xd0, bit [7:0] xp0, bit [7:0] xd1,
                              bit [7:0] xp1, bit [1:0] xh, bit xf);
    vec_t v;
    v.rst_n = r; v.en = en; v.tk = tk; v.ld = ld; v.d0 = d0; v.d1 = d1;
    v.err = err; v.clr = clr; v.xd0 = xd0; v.xp0 = xp0; v.xd1 = xd1;
    v.xp1 = xp1; v.xh = xh; v.xf = xf;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(bit r, bit en, bit tk, bit [1:0] ld, bit [7:0] d0,
                       bit [7:0] d1, bit err, bit clr);
    reset           = r;
    bus.enable      = en;
    bus.tick        = tk;
    bus.load        = ld;
    bus.data_in     = {d1, d0};
    bus.error       = err;
    bus.clear_error = clr;
    @(posedge clock);
    #1;
  endtask

  // Reference behaviour: one clock edge applied to the model.
  task automatic model_step(bit r, bit en, bit tk, bit [1:0] ld, bit [7:0] d0,
                            bit [7:0] d1, bit err, bit clr);
    int d[CH];
    d[0] = d0;
    d[1] = d1;
    if (!r) begin
      for (int c = 0; c < CH; c++) begin
        m_s[c] = 255; m_p[c] = 255; m_h[c] = HT;
      end
      m_f = 0;
      return;
    end
    if (en && !err) begin
      for (int c = 0; c < CH; c++) begin
        bit new_peak;
        new_peak = ld[c] && (d[c] >= m_p[c]);
        if (ld[c]) m_s[c] = d[c];
        if (new_peak) begin
          m_p[c] = d[c];
          m_h[c] = HT;
        end else if (tk) begin
          if (m_h[c] > 0) m_h[c]--;
          else begin
            int lowered;
            lowered = m_p[c] - DS;
            if (lowered < 0) lowered = 0;
            m_p[c] = (lowered > m_s[c]) ? lowered : m_s[c];
          end
        end
      end
    end
    if (en && err) m_f = 1;
    else if (clr && !err) m_f = 0;
  endtask

  initial begin
    bit [7:0] p;
    reset = 1'b0; bus.enable = 0; bus.tick = 0; bus.load = 0;
    bus.data_in = '0; bus.error = 0; bus.clear_error = 0;

    // reset with arbitrary inputs active
    vecs.push_back(mk(0,1,1,2'b11,8'h12,8'h34,1,0, 8'hFF,8'hFF,8'hFF,8'hFF,2'b11,0));
    vecs.push_back(mk(0,0,1,2'b10,8'h56,8'h78,0,1, 8'hFF,8'hFF,8'hFF,8'hFF,2'b11,0));
    // ch0 sample below peak: only the sample moves
    vecs.push_back(mk(1,1,0,2'b01,8'h80,8'h00,0,0, 8'h80,8'hFF,8'hFF,8'hFF,2'b11,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h80,8'hFF,8'hFF,8'hFF,2'b11,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h80,8'hFF,8'hFF,8'hFF,2'b00,0));
    // hold expired: ch0 decays from FF to its 0x80 floor, ch1 floored at FF
    p = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      p = (p - 8'd16 > 8'h80) ? p - 8'd16 : 8'h80;
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h80,p,8'hFF,8'hFF,2'b00,0));
    end
    // new peak 0x90, then lower sample 0x20, hold 4 ticks, decay to floor
    vecs.push_back(mk(1,1,0,2'b01,8'h90,0,0,0, 8'h90,8'h90,8'hFF,8'hFF,2'b01,0));
    vecs.push_back(mk(1,1,0,2'b01,8'h20,0,0,0, 8'h20,8'h90,8'hFF,8'hFF,2'b01,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h20,8'h90,8'hFF,8'hFF,2'b01,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h20,8'h90,8'hFF,8'hFF,2'b00,0));
    p = 8'h90;
    for (int k = 0; k < 8; k++) begin
      p = (p - 8'd16 > 8'h20) ? p - 8'd16 : 8'h20;
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h20,p,8'hFF,8'hFF,2'b00,0));
    end
    // peak 0x50 with counter 0, then load 0x60 together with a tick
    vecs.push_back(mk(1,1,0,2'b01,8'h50,0,0,0, 8'h50,8'h50,8'hFF,8'hFF,2'b01,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h50,8'h50,8'hFF,8'hFF,2'b01,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h50,8'h50,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,1,2'b01,8'h60,0,0,0, 8'h60,8'h60,8'hFF,8'hFF,2'b01,0));
    // bring ch0 to peak 0x40, counter 0, sample 0x10; then load 0x38 + tick
    vecs.push_back(mk(1,1,0,2'b01,8'h10,0,0,0, 8'h10,8'h60,8'hFF,8'hFF,2'b01,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h10,8'h60,8'hFF,8'hFF,2'b01,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h10,8'h60,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h10,8'h50,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,1,2'b00,0,0,0,0, 8'h10,8'h40,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,1,2'b01,8'h38,0,0,0, 8'h38,8'h38,8'hFF,8'hFF,2'b00,0));
    // error freeze and sticky flag handling
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,1,1,2'b11,8'h01,8'h02,1,0, 8'h38,8'h38,8'hFF,8'hFF,2'b00,1));
    vecs.push_back(mk(1,1,0,2'b00,0,0,0,1, 8'h38,8'h38,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,0,2'b00,0,0,1,1, 8'h38,8'h38,8'hFF,8'hFF,2'b00,1));
    vecs.push_back(mk(1,0,0,2'b00,0,0,1,1, 8'h38,8'h38,8'hFF,8'hFF,2'b00,1));
    vecs.push_back(mk(1,0,0,2'b00,0,0,0,1, 8'h38,8'h38,8'hFF,8'hFF,2'b00,0));
    // enable low freezes; then isolated ch1 load
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(1,0,1,2'b11,8'hAA,8'hBB,0,0, 8'h38,8'h38,8'hFF,8'hFF,2'b00,0));
    vecs.push_back(mk(1,1,0,2'b10,8'hAA,8'h33,0,0, 8'h38,8'h38,8'h33,8'hFF,2'b00,0));
    // reset mid-operation overrides everything
    vecs.push_back(mk(0,1,1,2'b11,8'hC0,8'hC1,0,0, 8'hFF,8'hFF,8'hFF,8'hFF,2'b11,0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      apply(v.rst_n, v.en, v.tk, v.ld, v.d0, v.d1, v.err, v.clr);
      check("vec_data",    i, 16'(bus.data_out), {v.xd1, v.xd0});
      check("vec_peak",    i, 16'(bus.peak_out), {v.xp1, v.xp0});
      check("vec_holding", i, 16'(bus.holding),  16'(v.xh));
      check("vec_flag",    i, 16'(bus.error_flag), 16'(v.xf));
    end

    // random phase against the reference model
    apply(0,0,0,2'b00,0,0,0,0);
    model_step(0,0,0,2'b00,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, en, tk, err, clr;
      bit [1:0] ld;
      bit [7:0] d0, d1;
      logic [15:0] exp_d, exp_p;
      logic [1:0]  exp_h;
      r   = ($urandom_range(0, 199) != 0);
      en  = ($urandom_range(0, 9) != 0);
      tk  = ($urandom_range(0, 1) == 1);
      ld  = 2'($urandom_range(0, 3) == 0) | (2'($urandom_range(0, 3) == 0) << 1);
      d0  = 8'($urandom_range(0, 255));
      d1  = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 9) == 0);
      apply(r, en, tk, ld, d0, d1, err, clr);
      model_step(r, en, tk, ld, d0, d1, err, clr);
      exp_d = {8'(m_s[1]), 8'(m_s[0])};
      exp_p = {8'(m_p[1]), 8'(m_p[0])};
      exp_h = {m_h[1] != 0, m_h[0] != 0};
      check("rnd_data",    n, 16'(bus.data_out), exp_d);
      check("rnd_peak",    n, 16'(bus.peak_out), exp_p);
      check("rnd_holding", n, 16'(bus.holding),  16'(exp_h));
      check("rnd_flag",    n, 16'(bus.error_flag), 16'(m_f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
